// File: rtl/cnt_rd_pkg.sv
// Shared definitions for the statistics-counter bank read master.
// Holds the FSM state encoding and the default bank geometry.
package cnt_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NCNT  = 8;
  localparam int DEF_TOMAX = 15;

endpackage

// File: rtl/cnt_bank_rd_sel.sv
// Combinational select of the addressed counter's ready flag and data word.
// Counters other than sel never influence the outputs.
module cnt_bank_rd_sel
  import cnt_rd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCNT  = DEF_NCNT,
  parameter int AW    = 3
) (
  input  logic [AW-1:0]         sel,
  input  logic [NCNT-1:0]       uprdy,
  input  logic [NCNT*WIDTH-1:0] updo,
  output logic                  rdy,
  output logic [WIDTH-1:0]      data
);

  always_comb begin
    rdy  = 1'b0;
    data = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (sel == AW'(i)) begin
        rdy  = uprdy[i];
        data = updo[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/cnt_bank_rd_master.sv
// CPU-side read master for a bank of statistics counters: decodes a read into
// one-hot enables plus a single uprs strobe, waits for uprdy, returns data/ack.
module cnt_bank_rd_master
  import cnt_rd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCNT  = DEF_NCNT,
  parameter int AW    = 3,
  parameter int TOMAX = DEF_TOMAX,
  parameter int TOW   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpurd,
  input  logic                  cpur2c,
  input  logic [AW-1:0]         cpuaddr,
  output logic                  cpubusy,
  output logic                  cpuack,
  output logic                  cpuerr,
  output logic [WIDTH-1:0]      cpudo,
  output logic [NCNT-1:0]       upen_ro,
  output logic [NCNT-1:0]       upen_r2c,
  output logic                  uprs,
  input  logic [NCNT-1:0]       uprdy,
  input  logic [NCNT*WIDTH-1:0] updo
);

  // Handshake: a request is taken only in IDLE; the selected enable stays high
  // from the strobe cycle until uprdy[sel] or timeout, uprs for the first cycle only.
  localparam logic [TOW-1:0] TLAST = TOW'(TOMAX - 1);

  state_t           state, state_n;
  logic [AW-1:0]    sel, sel_n;
  logic [TOW-1:0]   tcnt, tcnt_n;
  logic             ack_n, err_n, uprs_n, busy_n;
  logic [WIDTH-1:0] do_n;
  logic [NCNT-1:0]  ro_n, rc_n, addr_mask;
  logic             in_range, sel_rdy;
  logic [WIDTH-1:0] sel_data;

  cnt_bank_rd_sel #(.WIDTH(WIDTH), .NCNT(NCNT), .AW(AW)) u_sel (
    .sel   (sel),
    .uprdy (uprdy),
    .updo  (updo),
    .rdy   (sel_rdy),
    .data  (sel_data)
  );

  assign in_range = (int'(cpuaddr) < NCNT);

  always_comb begin
    addr_mask = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (cpuaddr == AW'(i)) addr_mask[i] = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    tcnt_n  = tcnt;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    uprs_n  = 1'b0;
    do_n    = cpudo;
    ro_n    = upen_ro;
    rc_n    = upen_r2c;
    case (state)
      IDLE: begin
        if (cpurd) begin
          if (in_range) begin
            state_n = ISSUE;
            sel_n   = cpuaddr;
            uprs_n  = 1'b1;
            if (cpur2c) rc_n = addr_mask;
            else        ro_n = addr_mask;
          end else begin
            state_n = DONE;
            ack_n   = 1'b1;
            err_n   = 1'b1;
            do_n    = '0;
          end
        end
      end
      ISSUE: begin
        if (sel_rdy) begin
          state_n = DONE;
          ack_n   = 1'b1;
          do_n    = sel_data;
          ro_n    = '0;
          rc_n    = '0;
        end else begin
          state_n = WAIT;
          tcnt_n  = '0;
        end
      end
      WAIT: begin
        if (sel_rdy) begin
          state_n = DONE;
          ack_n   = 1'b1;
          do_n    = sel_data;
          ro_n    = '0;
          rc_n    = '0;
        end else if (tcnt == TLAST) begin
          state_n = DONE;
          ack_n   = 1'b1;
          err_n   = 1'b1;
          do_n    = '0;
          ro_n    = '0;
          rc_n    = '0;
        end else begin
          tcnt_n = tcnt + TOW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      tcnt     <= '0;
      cpubusy  <= 1'b0;
      cpuack   <= 1'b0;
      cpuerr   <= 1'b0;
      cpudo    <= '0;
      upen_ro  <= '0;
      upen_r2c <= '0;
      uprs     <= 1'b0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      tcnt     <= tcnt_n;
      cpubusy  <= busy_n;
      cpuack   <= ack_n;
      cpuerr   <= err_n;
      cpudo    <= do_n;
      upen_ro  <= ro_n;
      upen_r2c <= rc_n;
      uprs     <= uprs_n;
    end
  end

endmodule

// File: tb/tb_cnt_bank_rd_master.sv
// Directed bench for cnt_bank_rd_master with a six-counter bank (AW = 3),
// so addresses 6 and 7 are out of range.
module tb_cnt_bank_rd_master;

  localparam int W  = 32;
  localparam int N  = 6;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cpurd = 1'b0;
  logic           cpur2c = 1'b0;
  logic [2:0]     cpuaddr = '0;
  logic           cpubusy, cpuack, cpuerr, uprs;
  logic [W-1:0]   cpudo;
  logic [N-1:0]   upen_ro, upen_r2c, uprdy;
  logic [N*W-1:0] updo;

  int total = 0;
  int bad   = 0;

  // Counter bank responder: snapshots on the strobe, clears on r2c strobe.
  logic [W-1:0] cval [N] = '{32'h11, 32'hC0DE_0001, 32'h2222, 32'h1234, 32'h4444, 32'hFF};
  logic [W-1:0] snap [N] = '{default: '0};
  logic [N-1:0] stuck = '0;
  logic [N-1:0] noise = '0;
  int           dly = 0;
  int           en_cycles = 0;

  cnt_bank_rd_master #(.WIDTH(W), .NCNT(N), .AW(3), .TOMAX(TO), .TOW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpurd    (cpurd),
    .cpur2c   (cpur2c),
    .cpuaddr  (cpuaddr),
    .cpubusy  (cpubusy),
    .cpuack   (cpuack),
    .cpuerr   (cpuerr),
    .cpudo    (cpudo),
    .upen_ro  (upen_ro),
    .upen_r2c (upen_r2c),
    .uprs     (uprs),
    .uprdy    (uprdy),
    .updo     (updo)
  );

  always #5 clk = ~clk;

  assign uprdy = ((upen_ro | upen_r2c) & ~stuck & {N{en_cycles >= dly}}) | noise;

  always_comb begin
    updo = '0;
    for (int i = 0; i < N; i++) updo[i*W +: W] = uprs ? cval[i] : snap[i];
  end

  always @(posedge clk) begin
    en_cycles <= (|(upen_ro | upen_r2c)) ? en_cycles + 1 : 0;
    for (int i = 0; i < N; i++) begin
      if (uprs && (upen_ro[i] || upen_r2c[i])) begin
        snap[i] <= cval[i];
        if (upen_r2c[i]) cval[i] <= '0;
      end
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one read and watches until cpuack (bounded); k counts cycles after the accepting edge.
  task automatic do_read(input logic [2:0] addr, input logic rc, input bit extra,
                         output int lat, output logic [W-1:0] data, output logic err,
                         output int n_uprs, output int n_en, output logic [N-1:0] ro_or,
                         output logic [N-1:0] rc_or, output int n_busy);
    lat = 0; data = 'x; err = 1'bx; n_uprs = 0; n_en = 0; ro_or = '0; rc_or = '0; n_busy = 0;
    @(negedge clk);
    cpuaddr = addr; cpur2c = rc; cpurd = 1'b1;
    @(posedge clk);
    #1 cpurd = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (extra && k == 1) begin
        cpurd = 1'b1; cpuaddr = 3'd4; cpur2c = 1'b0;
      end else begin
        cpurd = 1'b0;
      end
      if (uprs) n_uprs++;
      if (|(upen_ro | upen_r2c)) n_en++;
      ro_or |= upen_ro;
      rc_or |= upen_r2c;
      if (cpubusy) n_busy++;
      if (cpuack) begin
        lat = k; data = cpudo; err = cpuerr;
        break;
      end
    end
    cpurd = 1'b0;
  endtask

  initial begin
    int           lat, n_uprs, n_en, n_busy, acks;
    logic [W-1:0] data;
    logic         err;
    logic [N-1:0] ro_or, rc_or;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {cpubusy, cpuack, cpuerr, uprs, upen_ro, upen_r2c}, '0);
    check("rst_cpudo", cpudo, '0);
    rst = 1'b0;
    @(negedge clk);

    // Read-only, counter ready in the strobe cycle
    do_read(3'd3, 1'b0, 1'b0, lat, data, err, n_uprs, n_en, ro_or, rc_or, n_busy);
    check("ro_lat", lat, 2);
    check("ro_data", data, 32'h1234);
    check("ro_err", err, 0);
    check("ro_mask", ro_or, 6'b001000);
    check("ro_r2c_mask", rc_or, 0);
    check("ro_uprs", n_uprs, 1);
    check("ro_en_cycles", n_en, 1);
    repeat (3) @(negedge clk);
    check("ro_cpudo_held", cpudo, 32'h1234);
    do_read(3'd3, 1'b0, 1'b0, lat, data, err, n_uprs, n_en, ro_or, rc_or, n_busy);
    check("ro_again_data", data, 32'h1234);

    // Clear-on-read, then read-only shows the cleared value
    do_read(3'd5, 1'b1, 1'b0, lat, data, err, n_uprs, n_en, ro_or, rc_or, n_busy);
    check("r2c_data", data, 32'hFF);
    check("r2c_mask", rc_or, 6'b100000);
    check("r2c_ro_mask", ro_or, 0);
    check("r2c_uprs", n_uprs, 1);
    do_read(3'd5, 1'b0, 1'b0, lat, data, err, n_uprs, n_en, ro_or, rc_or, n_busy);
    check("r2c_after", data, 0);

    // Timeout: strobe cycle plus TO waiting cycles, ack right after
    stuck = 6'b000100;
    do_read(3'd2, 1'b0, 1'b0, lat, data, err, n_uprs, n_en, ro_or, rc_or, n_busy);
    check("to_lat", lat, 2 + TO);
    check("to_err", err, 1);
    check("to_data", data, 0);
    check("to_uprs", n_uprs, 1);
    check("to_en_cycles", n_en, TO + 1);
    check("to_mask", ro_or, 6'b000100);
    stuck = '0;

    // Out of range addresses
    do_read(3'd7, 1'b0, 1'b0, lat, data, err, n_uprs, n_en, ro_or, rc_or, n_busy);
    check("oor7_lat", lat, 1);
    check("oor7_err", err, 1);
    check("oor7_data", data, 0);
    check("oor7_activity", n_uprs + n_en, 0);
    do_read(3'd6, 1'b1, 1'b0, lat, data, err, n_uprs, n_en, ro_or, rc_or, n_busy);
    check("oor6_err", err, 1);
    check("oor6_masks", {ro_or, rc_or}, 0);

    // Delayed ready while non-selected counters assert uprdy with stale data
    dly = 3; noise = 6'b100001;
    do_read(3'd4, 1'b0, 1'b0, lat, data, err, n_uprs, n_en, ro_or, rc_or, n_busy);
    check("dly_lat", lat, 5);
    check("dly_data", data, 32'h4444);
    check("dly_err", err, 0);
    check("dly_en_cycles", n_en, 4);
    dly = 0; noise = '0;

    // Second cpurd during ISSUE is dropped
    do_read(3'd1, 1'b0, 1'b1, lat, data, err, n_uprs, n_en, ro_or, rc_or, n_busy);
    check("busy_data", data, 32'hC0DE_0001);
    check("busy_cycles", n_busy, 2);
    acks = 0;
    ro_or = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (cpuack) acks++;
      ro_or |= upen_ro | upen_r2c;
    end
    check("busy_extra_acks", acks, 0);
    check("busy_extra_en", ro_or, 0);

    // Reset in the middle of WAIT
    stuck = 6'b000100;
    @(negedge clk);
    cpuaddr = 3'd2; cpur2c = 1'b0; cpurd = 1'b1;
    @(posedge clk);
    #1 cpurd = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_wait_busy", cpubusy, 1);
    check("mid_wait_en", upen_ro, 6'b000100);
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", {cpubusy, cpuack, cpuerr, uprs, upen_ro, upen_r2c}, '0);
    check("mid_rst_cpudo", cpudo, '0);
    @(negedge clk);
    rst = 1'b0;
    stuck = '0;
    acks = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cpuack) acks++;
    end
    check("mid_rst_no_ack", acks, 0);
    do_read(3'd0, 1'b0, 1'b0, lat, data, err, n_uprs, n_en, ro_or, rc_or, n_busy);
    check("post_rst_lat", lat, 2);
    check("post_rst_data", data, 32'h11);
    check("post_rst_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
